// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the CPU/DMA RAM arbiter.
//   arb_state_e  : position within the CPU access window
//   WIN_LEN      : CPU window length in clk cycles
//   DATA_OFS     : offset of the data/write cycle inside the window
//   window_state : maps a phase offset (phase - window start) to a state
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU_ADDR,
    CPU_DATA,
    CPU_GUARD
  } arb_state_e;

  localparam int unsigned WIN_LEN  = 4;
  localparam int unsigned DATA_OFS = 1;

  function automatic arb_state_e window_state(input int unsigned offset);
    arb_state_e s;
    if (offset == 0)
      s = CPU_ADDR;
    else if (offset == DATA_OFS)
      s = CPU_DATA;
    else if (offset < WIN_LEN)
      s = CPU_GUARD;
    else
      s = IDLE;
    return s;
  endfunction

endpackage

// File: rtl/ram_arbiter_clk_phase_gen.sv
// Free-running phase counter with a divided clock taken from its MSB.
// Reusable by any peripheral that needs a clk/2^DIV_W clock plus phase.
//   clk     : system clock
//   reset   : synchronous active-high reset (phase -> 0)
//   phase   : DIV_W-bit counter, wraps 2^DIV_W-1 -> 0
//   div_clk : phase[DIV_W-1]; rises on the transition N/2-1 -> N/2
module clk_phase_gen #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [DIV_W-1:0] phase,
  output logic             div_clk
);

  always_ff @(posedge clk) begin
    if (reset)
      phase <= '0;
    else
      phase <= phase + DIV_W'(1);
  end

  assign div_clk = phase[DIV_W-1];

endmodule

// File: rtl/ram_arbiter.sv
// Time-division arbiter sharing one synchronous single-port RAM between a
// CPU (fixed window just before each cpu_clk rising edge) and a secondary
// DMA requester (any other cycle).
//   clk, reset                          : system clock, sync active-high reset
//   cpu_clk                             : generated CPU clock (clk / 2^CPU_DIV_W)
//   cpu_sel/we/addr/wdata, cpu_rdata    : CPU port, read data held per window
//   dma_req/we/addr/wdata               : DMA request, level held until ack
//   dma_ack, dma_rvalid, dma_rdata      : grant pulse, read-return pulse + data
//   ram_addr/we/wdata, ram_rdata        : spram32k8 port (1-cycle read latency)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned CPU_DIV_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_clk,
  input  logic        cpu_sel,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [14:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  localparam logic [CPU_DIV_W-1:0] W0 = CPU_DIV_W'((2 ** CPU_DIV_W) / 2 - WIN_LEN);

  logic [CPU_DIV_W-1:0] phase;
  logic [CPU_DIV_W-1:0] phase_nxt;
  logic [CPU_DIV_W-1:0] win_ofs;
  arb_state_e           state;
  arb_state_e           next_state;
  logic                 dma_grant;
  logic                 cpu_rd_cap;
  logic                 rd_pend;

  clk_phase_gen #(.DIV_W(CPU_DIV_W)) u_phase (
    .clk     (clk),
    .reset   (reset),
    .phase   (phase),
    .div_clk (cpu_clk)
  );

  // The state is registered, so it is decoded from the phase of the next
  // cycle; this keeps state aligned with phase while staying a pure function.
  assign phase_nxt = phase + CPU_DIV_W'(1);
  assign win_ofs   = phase_nxt - W0;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = window_state(32'(win_ofs));
  end

  always_comb begin
    dma_grant  = 1'b0;
    cpu_rd_cap = 1'b0;
    ram_addr   = dma_addr;
    ram_we     = 1'b0;
    ram_wdata  = dma_wdata;
    case (state)
      IDLE: begin
        dma_grant = dma_req & ~reset;
        ram_we    = dma_grant & dma_we;
      end
      CPU_ADDR: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      CPU_DATA: begin
        ram_addr   = cpu_addr;
        ram_wdata  = cpu_wdata;
        ram_we     = cpu_sel & cpu_we & ~reset;
        cpu_rd_cap = cpu_sel & ~cpu_we;
      end
      CPU_GUARD: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      default: begin
        ram_addr = dma_addr;
      end
    endcase
  end

  assign dma_ack = dma_grant;

  // rd_pend marks the cycle in which RAM returns data for a DMA read; it is
  // independent of the window so a read granted just before CPU_ADDR completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend    <= 1'b0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      rd_pend    <= dma_grant & ~dma_we;
      dma_rvalid <= rd_pend;
      if (rd_pend)
        dma_rdata <= ram_rdata;
      if (cpu_rd_cap)
        cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter (CPU_DIV_W = 4: 16-cycle frame, CPU window at
// phases 4..7, write at phase 5). A frame-level model checks every cycle;
// directed sequences add hand-computed literal expectations.
module tb_ram_arbiter;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_clk;
  logic        cpu_sel = 1'b0;
  logic        cpu_we = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [14:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic        dma_ack;
  logic        dma_rvalid;
  logic [7:0]  dma_rdata;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.CPU_DIV_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_clk    (cpu_clk),
    .cpu_sel    (cpu_sel),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  function automatic logic [7:0] init_val(input int unsigned a);
    return 8'(a) ^ 8'(a >> 7) ^ 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // spram32k8 stand-in: read-first, one-cycle read latency
  logic [7:0] mem [0:32767];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= init_val(i);
      ram_init <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  logic rst_q = 1'b1;
  always @(posedge clk) rst_q <= reset;

  // Frame-level model: phase = cycles since release mod N, shadow memory
  // updated by the accesses the rules say must happen.
  typedef struct {
    int         due;
    logic [7:0] data;
  } rd_t;

  initial begin
    logic [7:0]  shadow [0:32767];
    rd_t         rdq[$];
    int          cyc;
    int          abs_cyc;
    int          ph;
    bit          in_win;
    bit          exp_ack;
    bit          exp_we;
    bit          exp_rv;
    logic [7:0]  exp_cpu;
    logic [7:0]  exp_dma;
    logic [14:0] cpu_rd_addr;
    for (int i = 0; i < 32768; i++) shadow[i] = init_val(i);
    cyc = 0;
    abs_cyc = 0;
    exp_cpu = '0;
    exp_dma = '0;
    cpu_rd_addr = '0;
    forever begin
      @(negedge clk);
      abs_cyc++;
      if (rst_q) begin
        chk("rst_cpu_clk", cpu_clk, 0);
        chk("rst_rvalid", dma_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        rdq.delete();
        exp_cpu = '0;
        exp_dma = '0;
        cyc = 0;
      end
      if (reset) begin
        chk("rst_ack", dma_ack, 0);
        chk("rst_ram_we", ram_we, 0);
      end else begin
        ph = cyc % N;
        in_win = (ph >= 4) && (ph <= 7);
        chk("m_cpu_clk", cpu_clk, (ph >= 8));
        exp_ack = dma_req && !in_win;
        exp_we  = (ph == 5) ? (cpu_sel && cpu_we) : (exp_ack && dma_we);
        chk("m_ack", dma_ack, exp_ack);
        chk("m_ram_we", ram_we, exp_we);
        chk("m_ram_addr", ram_addr, in_win ? cpu_addr : dma_addr);
        if (exp_we) chk("m_ram_wdata", ram_wdata, (ph == 5) ? cpu_wdata : dma_wdata);
        exp_rv = 1'b0;
        if (rdq.size() > 0 && rdq[0].due == abs_cyc) begin
          exp_rv  = 1'b1;
          exp_dma = rdq[0].data;
          void'(rdq.pop_front());
        end
        chk("m_rvalid", dma_rvalid, exp_rv);
        chk("m_dma_rdata", dma_rdata, exp_dma);
        chk("m_cpu_rdata", cpu_rdata, exp_cpu);
        if (ph == 4) cpu_rd_addr = cpu_addr;
        if (ph == 5 && cpu_sel && !cpu_we) exp_cpu = shadow[cpu_rd_addr];
        if (ph == 5 && cpu_sel && cpu_we) shadow[cpu_addr] = cpu_wdata;
        if (exp_ack && !dma_we) rdq.push_back('{due: abs_cyc + 2, data: shadow[dma_addr]});
        if (exp_ack && dma_we) shadow[dma_addr] = dma_wdata;
        cyc++;
      end
    end
  end

  // Directed stimulus: inputs change 1 after posedge, literals sampled 3 after.
  int sph = 0;

  task automatic step();
    @(posedge clk);
    #1;
    sph = (sph + 1) % N;
  endtask

  task automatic goto_phase(input int p);
    for (int k = 0; k < N && sph != p; k++) step();
  endtask

  initial begin
    int we_cnt;
    int we_ph;
    int acks;
    int ack_in_win;
    int cyc_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    sph = 0;

    // cpu_clk shape over one frame
    for (int p = 0; p < N; p++) begin
      #2;
      chk($sformatf("cpu_clk_ph%0d", p), cpu_clk, (p >= 8));
      step();
    end

    // CPU write 0xA5 to 0x1234, then read it back
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'hA5;
    we_cnt = 0; we_ph = -1;
    for (int p = 0; p < N; p++) begin
      #2;
      if (ram_we) begin we_cnt++; we_ph = sph; end
      step();
    end
    chk("cpu_wr_pulses", we_cnt, 1);
    chk("cpu_wr_phase", we_ph, 5);
    cpu_we = 1'b0;
    goto_phase(5);
    #2 chk("cpu_rd_before", cpu_rdata, 8'h00);
    step();
    #2 chk("cpu_rd_after", cpu_rdata, 8'hA5);
    cpu_sel = 1'b0;
    goto_phase(0);

    // continuous DMA reads of 0x0000..0x000F
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = '0;
    acks = 0; ack_in_win = 0; cyc_cnt = 0;
    while (acks < 16 && cyc_cnt < 64) begin
      #2;
      if (dma_ack) begin
        acks++;
        if (sph >= 4 && sph <= 7) ack_in_win++;
      end
      cyc_cnt++;
      step();
      dma_addr = 15'(acks);
      if (acks == 16) dma_req = 1'b0;
    end
    chk("dma_burst_acks", acks, 16);
    chk("dma_burst_win_acks", ack_in_win, 0);
    chk("dma_burst_cycles", cyc_cnt, 20);
    step();
    #2;
    chk("dma_last_rvalid", dma_rvalid, 1);
    chk("dma_last_rdata", dma_rdata, 8'h33);

    // request raised at window start is stalled to phase 8
    goto_phase(4);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0100;
    for (int p = 4; p < 8; p++) begin
      #2 chk($sformatf("stall_ack_ph%0d", p), dma_ack, 0);
      step();
    end
    #2 chk("stall_ack_ph8", dma_ack, 1);
    step();
    dma_req = 1'b0;

    // DMA write 0x77 to 0x0300
    goto_phase(10);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h0300; dma_wdata = 8'h77;
    #2;
    chk("dma_wr_ack", dma_ack, 1);
    chk("dma_wr_we", ram_we, 1);
    step();
    dma_req = 1'b0; dma_we = 1'b0;

    // DMA read at phase 3 overlapping a CPU read of another address
    goto_phase(0);
    cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0200;
    goto_phase(3);
    dma_req = 1'b1; dma_addr = 15'h0300;
    #2 chk("edge_ack_ph3", dma_ack, 1);
    step();
    dma_req = 1'b0;
    step();
    #2;
    chk("edge_rvalid", dma_rvalid, 1);
    chk("edge_dma_rdata", dma_rdata, 8'h77);
    step();
    #2 chk("edge_cpu_rdata", cpu_rdata, 8'h38);
    cpu_sel = 1'b0;

    // reset one cycle after a DMA read ack
    goto_phase(10);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0005;
    #2 chk("rst_case_ack", dma_ack, 1);
    step();
    dma_req = 1'b0;
    reset = 1'b1;
    #2 chk("rst_case_ack_t1", dma_ack, 0);
    step();
    dma_req = 1'b1;
    #2;
    chk("rst_case_rvalid", dma_rvalid, 0);
    chk("rst_case_cpu_clk", cpu_clk, 0);
    chk("rst_case_cpu_rdata", cpu_rdata, 0);
    chk("rst_case_dma_rdata", dma_rdata, 0);
    chk("rst_case_ram_we", ram_we, 0);
    chk("rst_case_ack_t2", dma_ack, 0);
    step();
    #2 chk("rst_case_ack_t3", dma_ack, 0);
    step();
    dma_req = 1'b0;
    reset = 1'b0;
    sph = 0;
    #2 chk("post_rst_cpu_clk", cpu_clk, 0);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
